// File: rtl/spi_pixel_master_pkg.sv
// Shared definitions for the SPI pixel master: FSM states, parameter defaults
// and a small elaboration-time helper.
package spi_pixel_master_pkg;

   localparam int MAX_PIXEL_BITS = 24;
   localparam int DEF_CLK_DIV    = 4;
   localparam int DEF_CS_GAP     = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/spi_pixel_master_sck_gen.sv
// SCK generator: half-period counter, registered CPOL=0 clock and one-cycle
// rise/fall strobes that coincide with the clk edge that moves SCK.
module spi_pixel_master_sck_gen
   import spi_pixel_master_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic start_i,
   input  logic en_i,
   output logic sck_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int HALF_W = $clog2(CLK_DIV);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);

   logic [HALF_W-1:0] half_cnt;
   logic              half_done;

   assign half_done = (half_cnt == HALF_LAST);

   // start_i produces the first rising edge so SCK rises exactly at the end of
   // the setup window instead of one cycle after SHIFT is entered.
   assign rise_o = start_i | (en_i & half_done & ~sck_o);
   assign fall_o = en_i & half_done & sck_o;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         half_cnt <= '0;
         sck_o    <= 1'b0;
      end else if (start_i) begin
         half_cnt <= '0;
         sck_o    <= 1'b1;
      end else if (en_i) begin
         if (half_done) begin
            half_cnt <= '0;
            sck_o    <= ~sck_o;
         end else begin
            half_cnt <= half_cnt + 1'b1;
         end
      end else begin
         half_cnt <= '0;
         sck_o    <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_pixel_master.sv
// Host-side SPI master (CPOL=0/CPHA=0, MSB first): sends one pixel word per
// valid/ready handshake and returns the word captured from SDO.
module spi_pixel_master
   import spi_pixel_master_pkg::*;
#(
   parameter int PIXEL_BITS = MAX_PIXEL_BITS,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CS_GAP     = DEF_CS_GAP
) (
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic [PIXEL_BITS-1:0] tx_px_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [PIXEL_BITS-1:0] rx_px_o,
   output logic                  rx_valid_o,
   output logic                  busy_o,
   output logic                  spi_sck_o,
   output logic                  spi_cs_o,
   output logic                  spi_sdi_o,
   input  logic                  spi_sdo_i
);

   localparam int BIT_W  = $clog2(PIXEL_BITS + 1);
   localparam int WAIT_W = $clog2(max_int(CLK_DIV, CS_GAP));

   localparam logic [WAIT_W-1:0] DIV_LAST = WAIT_W'(CLK_DIV - 1);
   localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(CS_GAP - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PIXEL_BITS);

   state_t                state;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [PIXEL_BITS-1:0] tx_sr;
   logic [PIXEL_BITS-1:0] rx_sr;
   logic                  sck_start;
   logic                  sck_en;
   logic                  sck_rise;
   logic                  sck_fall;

   assign tx_ready_o = (state == ST_IDLE);
   assign busy_o     = (state != ST_IDLE);
   // The shift register MSB is itself a flop, so SDI stays glitch-free.
   assign spi_sdi_o  = tx_sr[PIXEL_BITS-1];

   assign sck_start = (state == ST_SETUP) && (wait_cnt == DIV_LAST);
   assign sck_en    = (state == ST_SHIFT);

   spi_pixel_master_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .start_i  (sck_start),
      .en_i     (sck_en),
      .sck_o    (spi_sck_o),
      .rise_o   (sck_rise),
      .fall_o   (sck_fall)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         bit_cnt    <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
         rx_px_o    <= '0;
         rx_valid_o <= 1'b0;
         spi_cs_o   <= 1'b1;
      end else begin
         rx_valid_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_valid_i) begin
                  tx_sr    <= tx_px_i;
                  wait_cnt <= '0;
                  bit_cnt  <= '0;
                  spi_cs_o <= 1'b0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (wait_cnt == DIV_LAST) begin
                  // The generator raises SCK on this edge; count it as bit 1.
                  wait_cnt <= '0;
                  bit_cnt  <= BIT_W'(1);
                  state    <= ST_SHIFT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (sck_rise) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
               if (sck_fall) begin
                  rx_sr <= {rx_sr[PIXEL_BITS-2:0], spi_sdo_i};
                  tx_sr <= tx_sr << 1;
                  if (bit_cnt == BIT_LAST) begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (wait_cnt == DIV_LAST) begin
                  wait_cnt   <= '0;
                  spi_cs_o   <= 1'b1;
                  rx_px_o    <= rx_sr;
                  rx_valid_o <= 1'b1;
                  state      <= ST_GAP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               if (wait_cnt == GAP_LAST) begin
                  wait_cnt <= '0;
                  state    <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               spi_cs_o <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_pixel_master.sv
// Self-checking bench for spi_pixel_master: table-driven transactions on a
// CLK_DIV=2 instance plus hand-written back-to-back, CLK_DIV=4 and reset cases.
module tb_spi_pixel_master;

   localparam int PB  = 24;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic nreset = 1'b0;

   initial forever #5 clk = ~clk;

   // Instance A: CLK_DIV=2, SDO from loopback or the slave model.
   logic [PB-1:0] tx_px_a = '0;
   logic          tx_valid_a = 1'b0;
   logic          tx_ready_a, rx_valid_a, busy_a, sck_a, cs_a, sdi_a, sdo_a;
   logic [PB-1:0] rx_px_a;
   logic          sdo_mode = 1'b0;
   logic          slave_sdo = 1'b0;

   assign sdo_a = sdo_mode ? slave_sdo : sdi_a;

   spi_pixel_master #(.PIXEL_BITS(PB), .CLK_DIV(2), .CS_GAP(GAP)) dut_a (
      .clk_i      (clk),
      .nreset_i   (nreset),
      .tx_px_i    (tx_px_a),
      .tx_valid_i (tx_valid_a),
      .tx_ready_o (tx_ready_a),
      .rx_px_o    (rx_px_a),
      .rx_valid_o (rx_valid_a),
      .busy_o     (busy_a),
      .spi_sck_o  (sck_a),
      .spi_cs_o   (cs_a),
      .spi_sdi_o  (sdi_a),
      .spi_sdo_i  (sdo_a)
   );

   // Instance B: CLK_DIV=4, loopback.
   logic [PB-1:0] tx_px_b = '0;
   logic          tx_valid_b = 1'b0;
   logic          tx_ready_b, rx_valid_b, busy_b, sck_b, cs_b, sdi_b;
   logic [PB-1:0] rx_px_b;

   spi_pixel_master #(.PIXEL_BITS(PB), .CLK_DIV(4), .CS_GAP(GAP)) dut_b (
      .clk_i      (clk),
      .nreset_i   (nreset),
      .tx_px_i    (tx_px_b),
      .tx_valid_i (tx_valid_b),
      .tx_ready_o (tx_ready_b),
      .rx_px_o    (rx_px_b),
      .rx_valid_o (rx_valid_b),
      .busy_o     (busy_b),
      .spi_sck_o  (sck_b),
      .spi_cs_o   (cs_b),
      .spi_sdi_o  (sdi_b),
      .spi_sdo_i  (sdi_b)
   );

   int errors = 0;
   int checks = 0;
   int sck_cs_viol = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // SCK must never be high while CS is deasserted.
   initial forever begin
      @(negedge clk);
      if (nreset && ((sck_a && cs_a) || (sck_b && cs_b))) sck_cs_viol++;
   end

   // Slave model: fixed word, next bit presented one clk after each SCK fall.
   logic [PB-1:0] slave_word = 24'h0000FF;
   int            slave_idx = PB - 1;
   bit            slave_pend = 1'b0;
   logic          slave_prev_sck = 1'b0;

   initial forever begin
      @(negedge clk);
      if (cs_a) begin
         slave_idx  = PB - 1;
         slave_pend = 1'b0;
      end else begin
         if (slave_pend) begin
            slave_idx--;
            slave_pend = 1'b0;
         end
         if (slave_prev_sck && !sck_a) slave_pend = 1'b1;
      end
      slave_prev_sck = sck_a;
      slave_sdo = (slave_idx >= 0) ? slave_word[slave_idx] : 1'b0;
   end

   typedef struct {
      logic [PB-1:0] tx;
      bit            slave;
      bit            disturb;
      logic [PB-1:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   // Handshake edge is T; cycle c=1 is the first negedge after T.
   // CLK_DIV=2: rx_valid at 1+2*(2*24+1)=99, tx_ready at 99+CS_GAP=101.
   task automatic run_vec(input int n, input vec_t v);
      int            cs_fall_c = -1;
      int            valid_c = -1;
      int            ready_c = -1;
      int            valid_cnt = 0;
      int            rises = 0;
      logic [PB-1:0] sdi_word = '0;
      logic [PB-1:0] rx_got = '0;
      logic          prev = 1'b0;
      string         tag;
      tag = $sformatf("v%0d", n);
      sdo_mode = v.slave;
      @(negedge clk);
      check({tag, "_ready_before"}, 32'(tx_ready_a), 32'd1);
      tx_px_a = v.tx;
      tx_valid_a = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 250; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid_a = 1'b0;
         if (v.disturb) begin
            if (c >= 10 && c <= 40) begin
               tx_px_a = ~v.tx;
               tx_valid_a = (c % 2 == 1);
            end else if (c == 41) begin
               tx_valid_a = 1'b0;
            end
         end
         if (!cs_a && cs_fall_c < 0) cs_fall_c = c;
         if (sck_a && !prev) begin
            rises++;
            sdi_word = {sdi_word[PB-2:0], sdi_a};
         end
         prev = sck_a;
         if (rx_valid_a) begin
            valid_cnt++;
            valid_c = c;
            rx_got = rx_px_a;
         end
         if (tx_ready_a) begin
            ready_c = c;
            break;
         end
      end
      tx_valid_a = 1'b0;
      check({tag, "_cs_fall_cycle"}, 32'(cs_fall_c), 32'd1);
      check({tag, "_sck_rises"},     32'(rises),     32'd24);
      check({tag, "_sdi_word"},      32'(sdi_word),  32'(v.tx));
      check({tag, "_rx_valid_count"},32'(valid_cnt), 32'd1);
      check({tag, "_rx_valid_cycle"},32'(valid_c),   32'd99);
      check({tag, "_rx_px"},         32'(rx_got),    32'(v.exp_rx));
      check({tag, "_ready_cycle"},   32'(ready_c),   32'd101);
      @(negedge clk);
      check({tag, "_rx_px_hold"},    32'(rx_px_a),   32'(v.exp_rx));
   endtask

   task automatic run_back_to_back();
      logic [2*PB-1:0] sdi_word = '0;
      logic [PB-1:0]   rx1 = '0;
      logic [PB-1:0]   rx2 = '0;
      int              rises = 0;
      int              vcnt = 0;
      int              v2_c = -1;
      int              cs_hi = 0;
      bit              rose = 1'b0;
      bit              fall2 = 1'b0;
      bit              done = 1'b0;
      logic            prev = 1'b0;
      sdo_mode = 1'b0;
      @(negedge clk);
      tx_px_a = 24'h000001;
      tx_valid_a = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (c == 1) tx_px_a = 24'hFFFFFF;
         if (sck_a && !prev) begin
            rises++;
            sdi_word = {sdi_word[2*PB-2:0], sdi_a};
         end
         prev = sck_a;
         if (rx_valid_a) begin
            vcnt++;
            if (vcnt == 1) rx1 = rx_px_a;
            else begin
               rx2 = rx_px_a;
               v2_c = c;
            end
         end
         if (c > 1 && cs_a && !fall2) begin
            rose = 1'b1;
            cs_hi++;
         end else if (rose && !cs_a && !fall2) begin
            fall2 = 1'b1;
            tx_valid_a = 1'b0;
         end
         if (fall2 && tx_ready_a) begin
            done = 1'b1;
            break;
         end
      end
      tx_valid_a = 1'b0;
      check("b2b_done",        32'(done),              32'd1);
      check("b2b_sck_rises",   32'(rises),             32'd48);
      check("b2b_sdi_word1",   32'(sdi_word[2*PB-1:PB]), 32'h000001);
      check("b2b_sdi_word2",   32'(sdi_word[PB-1:0]),  32'hFFFFFF);
      // CS high spans the GAP state plus the IDLE cycle that takes the handshake.
      check("b2b_cs_high_cycles", 32'(cs_hi),          32'(GAP + 1));
      check("b2b_rx_count",    32'(vcnt),              32'd2);
      check("b2b_rx1",         32'(rx1),               32'h000001);
      check("b2b_rx2",         32'(rx2),               32'hFFFFFF);
      check("b2b_rx2_cycle",   32'(v2_c),              32'd200);
   endtask

   task automatic run_div4();
      int   rise_c[PB];
      int   fall_c[PB];
      int   rises = 0;
      int   falls = 0;
      int   cs_fall_c = -1;
      int   cs_rise_c = -1;
      int   ready_c = -1;
      int   hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
      logic [PB-1:0] rx_got = '0;
      logic prev = 1'b0;
      @(negedge clk);
      tx_px_b = 24'hC0FFEE;
      tx_valid_b = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid_b = 1'b0;
         if (!cs_b && cs_fall_c < 0) cs_fall_c = c;
         if (cs_b && cs_fall_c > 0 && cs_rise_c < 0) cs_rise_c = c;
         if (sck_b && !prev) begin
            if (rises < PB) rise_c[rises] = c;
            rises++;
         end
         if (!sck_b && prev) begin
            if (falls < PB) fall_c[falls] = c;
            falls++;
         end
         prev = sck_b;
         if (rx_valid_b) rx_got = rx_px_b;
         if (tx_ready_b) begin
            ready_c = c;
            break;
         end
      end
      check("div4_rises", 32'(rises), 32'd24);
      check("div4_falls", 32'(falls), 32'd24);
      if (rises == PB && falls == PB) begin
         for (int k = 0; k < PB; k++) begin
            hi_min = (fall_c[k] - rise_c[k] < hi_min) ? fall_c[k] - rise_c[k] : hi_min;
            hi_max = (fall_c[k] - rise_c[k] > hi_max) ? fall_c[k] - rise_c[k] : hi_max;
            if (k < PB - 1) begin
               lo_min = (rise_c[k+1] - fall_c[k] < lo_min) ? rise_c[k+1] - fall_c[k] : lo_min;
               lo_max = (rise_c[k+1] - fall_c[k] > lo_max) ? rise_c[k+1] - fall_c[k] : lo_max;
            end
         end
         check("div4_cs_lead", 32'(rise_c[0] - cs_fall_c),  32'd4);
         check("div4_cs_lag",  32'(cs_rise_c - fall_c[PB-1]), 32'd4);
      end
      check("div4_high_min", 32'(hi_min), 32'd4);
      check("div4_high_max", 32'(hi_max), 32'd4);
      check("div4_low_min",  32'(lo_min), 32'd4);
      check("div4_low_max",  32'(lo_max), 32'd4);
      check("div4_rx_px",    32'(rx_got), 32'hC0FFEE);
      check("div4_ready_cycle", 32'(ready_c), 32'd199);
   endtask

   task automatic run_mid_reset();
      bit mid = 1'b0;
      int vcnt = 0;
      sdo_mode = 1'b0;
      @(negedge clk);
      tx_px_a = 24'hFFFFFF;
      tx_valid_a = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         tx_valid_a = 1'b0;
         if (c > 8 && sck_a && !cs_a) begin
            mid = 1'b1;
            break;
         end
      end
      check("rst_mid_found_sck_high", 32'(mid), 32'd1);
      #2 nreset = 1'b0;
      #1;
      check("rst_mid_cs",    32'(cs_a),       32'd1);
      check("rst_mid_sck",   32'(sck_a),      32'd0);
      check("rst_mid_ready", 32'(tx_ready_a), 32'd1);
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      for (int c = 0; c < 150; c++) begin
         @(negedge clk);
         if (rx_valid_a) vcnt++;
      end
      check("rst_mid_no_rx_valid", 32'(vcnt),    32'd0);
      check("rst_mid_rx_px",       32'(rx_px_a), 32'd0);
   endtask

   initial begin
      vecs[0] = '{tx: 24'hA5C30F, slave: 1'b0, disturb: 1'b0, exp_rx: 24'hA5C30F};
      vecs[1] = '{tx: 24'h5A3CF0, slave: 1'b0, disturb: 1'b0, exp_rx: 24'h5A3CF0};
      vecs[2] = '{tx: 24'h123456, slave: 1'b1, disturb: 1'b0, exp_rx: 24'h0000FF};
      vecs[3] = '{tx: 24'h3C3C3C, slave: 1'b0, disturb: 1'b1, exp_rx: 24'h3C3C3C};
      vecs[4] = '{tx: 24'h800001, slave: 1'b0, disturb: 1'b0, exp_rx: 24'h800001};

      repeat (3) @(negedge clk);
      check("rst_cs",       32'(cs_a),       32'd1);
      check("rst_sck",      32'(sck_a),      32'd0);
      check("rst_sdi",      32'(sdi_a),      32'd0);
      check("rst_ready",    32'(tx_ready_a), 32'd1);
      check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
      check("rst_busy",     32'(busy_a),     32'd0);
      check("rst_rx_px",    32'(rx_px_a),    32'd0);
      check("rst_cs_b",     32'(cs_b),       32'd1);
      nreset = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_vec(i, vecs[i]);
         repeat (3) @(negedge clk);
      end

      run_back_to_back();
      repeat (3) @(negedge clk);
      run_div4();
      repeat (3) @(negedge clk);
      run_mid_reset();

      check("sck_high_while_cs_high", 32'(sck_cs_viol), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
